// File: rtl/dram_device_if.sv
// Pin bundle between the on-chip DRAM controller (master) and the DRAM device (slave).
// Command, address and write-data go out; read data and its strobe come back.
interface dram_device_if #(
    parameter int unsigned AW = 11
);
    logic          CSn;
    logic          RASn;
    logic          CASn;
    logic [3:0]    WEn;
    logic [AW-1:0] A;
    logic [31:0]   D;
    logic [31:0]   Q;
    logic          VALID;

    modport master (
        output CSn, RASn, CASn, WEn, A, D,
        input  Q, VALID
    );

    modport slave (
        input  CSn, RASn, CASn, WEn, A, D,
        output Q, VALID
    );
endinterface

// File: rtl/dram_device.sv
// Behavioural single-rank DRAM: row/column multiplexed, byte-writable 32-bit words,
// pipelined reads returned CAS_LAT cycles after the command with a one-cycle VALID.
module dram_device #(
    parameter int unsigned ROW_W   = 11,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned CAS_LAT = 5,
    parameter int unsigned T_RCD   = 2
) (
    input  logic          CK,
    input  logic          RST,
    dram_device_if.slave  bus
);

    localparam int unsigned AddrW = ROW_W + COL_W;
    localparam int unsigned Depth = 2 ** AddrW;
    localparam int unsigned RcdW  = (T_RCD > 0) ? $clog2(T_RCD + 1) : 1;
    // ACT edge counts as the first cycle, so READ/WRITE is legal T_RCD edges later.
    localparam logic [RcdW-1:0] RcdLoad = (T_RCD > 0) ? RcdW'(T_RCD - 1) : '0;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [7:0] Memory_byte0 [Depth];
    logic [7:0] Memory_byte1 [Depth];
    logic [7:0] Memory_byte2 [Depth];
    logic [7:0] Memory_byte3 [Depth];

    state_e            r_state, w_state_next;
    logic [ROW_W-1:0]  r_row, w_row_next;
    logic [RcdW-1:0]   r_rcd, w_rcd_next;
    logic              w_rd, w_wr;
    logic [AddrW-1:0]  w_addr;
    logic [31:0]       w_rdata;

    logic [CAS_LAT-1:0] r_pipe_v;
    logic [31:0]        r_pipe_d [CAS_LAT];
    logic               r_valid;
    logic [31:0]        r_q;

    assign w_addr  = {r_row, bus.A[COL_W-1:0]};
    assign w_rdata = {Memory_byte3[w_addr], Memory_byte2[w_addr],
                      Memory_byte1[w_addr], Memory_byte0[w_addr]};

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_rcd_next   = (r_rcd != '0) ? r_rcd - 1'b1 : r_rcd;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!bus.CSn && !bus.RASn && bus.CASn) begin
                    w_state_next = StActive;
                    w_row_next   = bus.A[ROW_W-1:0];
                    w_rcd_next   = RcdLoad;
                end
            end
            StActive: begin
                if (!bus.CSn) begin
                    if (bus.RASn) begin
                        w_state_next = StIdle;
                    end else if (!bus.CASn && (r_rcd == '0)) begin
                        w_rd = (bus.WEn == 4'hF);
                        w_wr = (bus.WEn != 4'hF);
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_rcd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_rcd   <= w_rcd_next;
        end
    end

    // Storage is deliberately not reset so preloaded contents survive RST.
    always_ff @(posedge CK) begin
        if (w_wr && !RST) begin
            if (!bus.WEn[0]) Memory_byte0[w_addr] <= bus.D[7:0];
            if (!bus.WEn[1]) Memory_byte1[w_addr] <= bus.D[15:8];
            if (!bus.WEn[2]) Memory_byte2[w_addr] <= bus.D[23:16];
            if (!bus.WEn[3]) Memory_byte3[w_addr] <= bus.D[31:24];
        end
    end

    always_ff @(posedge CK) begin
        r_pipe_d[0] <= w_rdata;
        for (int i = 1; i < CAS_LAT; i++) begin
            r_pipe_d[i] <= r_pipe_d[i-1];
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_pipe_v <= '0;
            r_valid  <= 1'b0;
            r_q      <= '0;
        end else begin
            r_pipe_v[0] <= w_rd;
            for (int i = 1; i < CAS_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
            end
            r_valid <= r_pipe_v[CAS_LAT-1];
            r_q     <= r_pipe_v[CAS_LAT-1] ? r_pipe_d[CAS_LAT-1] : '0;
        end
    end

    assign bus.Q     = r_q;
    assign bus.VALID = r_valid;

endmodule

// File: tb/tb_dram_device.sv
// Randomised bench for dram_device: a cycle-counting command model predicts every
// VALID/Q pair; directed scenarios also check fixed values from the test plan.
module tb_dram_device;

    localparam int unsigned CAS_LAT = 5;
    localparam int unsigned T_RCD   = 2;

    logic CK = 1'b0;
    logic RST;

    dram_device_if #(.AW(11)) bus ();

    dram_device #(
        .ROW_W  (11),
        .COL_W  (10),
        .CAS_LAT(CAS_LAT),
        .T_RCD  (T_RCD)
    ) dut (
        .CK (CK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CK = ~CK;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] ref_mem [int unsigned];
    rd_t         m_q [$];
    bit          m_open;
    logic [10:0] m_row;
    int unsigned m_act_cyc;

    logic        exp_valid, obs_valid;
    logic [31:0] exp_q, obs_q;

    function automatic int unsigned waddr(input logic [10:0] row, input logic [10:0] col);
        return 32'({row, col[9:0]});
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    endfunction

    task automatic preload(input int unsigned addr, input logic [31:0] data);
        dut.Memory_byte0[addr[20:0]] = data[7:0];
        dut.Memory_byte1[addr[20:0]] = data[15:8];
        dut.Memory_byte2[addr[20:0]] = data[23:16];
        dut.Memory_byte3[addr[20:0]] = data[31:24];
        ref_mem[addr] = data;
    endtask

    // Drive one command, clock it, advance the model, sample outputs 1 time unit later.
    task automatic step(input logic rst, input logic csn, input logic rasn, input logic casn,
                        input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
        int unsigned addr;
        logic [31:0] w;
        RST = rst; bus.CSn = csn; bus.RASn = rasn; bus.CASn = casn;
        bus.WEn = wen; bus.A = a; bus.D = d;
        @(posedge CK);
        cyc++;
        if (rst) begin
            m_open = 1'b0;
            m_q.delete();
        end else if (!csn) begin
            if (!m_open) begin
                if (!rasn && casn) begin
                    m_open = 1'b1; m_row = a; m_act_cyc = cyc;
                end
            end else if (rasn) begin
                m_open = 1'b0;
            end else if (!casn && (cyc - m_act_cyc) >= T_RCD) begin
                addr = waddr(m_row, a);
                if (wen == 4'hF) begin
                    m_q.push_back('{due: cyc + CAS_LAT, data: ref_rd(addr)});
                end else begin
                    w = ref_rd(addr);
                    for (int b = 0; b < 4; b++) if (!wen[b]) w[8*b +: 8] = d[8*b +: 8];
                    ref_mem[addr] = w;
                end
            end
        end
        #1;
        exp_valid = 1'b0;
        exp_q     = 32'h0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            exp_valid = 1'b1;
            exp_q     = m_q[0].data;
            void'(m_q.pop_front());
        end
        obs_valid = bus.VALID;
        obs_q     = bus.Q;
    endtask

    task automatic test_reset;
        logic [31:0] word;
        preload(32'h40000, 32'h12345678);
        step(1, 1, 1, 1, 4'hF, 11'h0, 32'h0);
        step(1, 1, 1, 1, 4'hF, 11'h0, 32'h0);
        n_cmp++;
        if (obs_valid !== 1'b0 || obs_q !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_out: got valid=%b q=%h, want valid=0 q=00000000", obs_valid, obs_q);
        end
        word = {dut.Memory_byte3[21'h40000], dut.Memory_byte2[21'h40000],
                dut.Memory_byte1[21'h40000], dut.Memory_byte0[21'h40000]};
        n_cmp++;
        if (word !== 32'h12345678) begin
            n_bad++;
            $display("FAIL reset_mem: got %h, want 12345678", word);
        end
    endtask

    task automatic test_write_read;
        int unsigned rd_cyc, seen_cyc;
        logic [31:0] seen_q, word;
        seen_cyc = 0; seen_q = 32'h0;
        step(0, 0, 0, 1, 4'hF, 11'h100, 32'h0);
        step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
        step(0, 0, 0, 0, 4'h0, 11'h004, 32'hDEADBEEF);
        step(0, 0, 0, 0, 4'hF, 11'h004, 32'h0);
        rd_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
            if (obs_valid === 1'b1 && seen_cyc == 0) begin seen_cyc = cyc; seen_q = obs_q; end
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL wr_rd_cycle: got valid=%b q=%h, want valid=%b q=%h",
                         obs_valid, obs_q, exp_valid, exp_q);
            end
        end
        n_cmp++;
        if (seen_cyc != rd_cyc + CAS_LAT || seen_q !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_rd_latency: got +%0d q=%h, want +%0d q=deadbeef",
                     seen_cyc - rd_cyc, seen_q, CAS_LAT);
        end
        word = {dut.Memory_byte3[21'h40004], dut.Memory_byte2[21'h40004],
                dut.Memory_byte1[21'h40004], dut.Memory_byte0[21'h40004]};
        n_cmp++;
        if (word !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL wr_rd_array: got %h, want deadbeef", word);
        end
    endtask

    task automatic test_byte_mask;
        logic [31:0] seen_q;
        int n_valid;
        seen_q = 32'h0; n_valid = 0;
        step(0, 0, 0, 0, 4'b1010, 11'h004, 32'h11223344);
        step(0, 0, 0, 0, 4'hF, 11'h004, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
            if (obs_valid === 1'b1) begin n_valid++; seen_q = obs_q; end
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL mask_cycle: got valid=%b q=%h, want valid=%b q=%h",
                         obs_valid, obs_q, exp_valid, exp_q);
            end
        end
        n_cmp++;
        if (n_valid != 1 || seen_q !== 32'hDE22BE44) begin
            n_bad++;
            $display("FAIL mask_data: got %0d pulses q=%h, want 1 pulse q=de22be44",
                     n_valid, seen_q);
        end
    endtask

    task automatic test_timing_guard;
        int unsigned rd_cyc, first_cyc;
        int n_valid;
        first_cyc = 0; n_valid = 0;
        step(0, 0, 1, 1, 4'hF, 11'h0, 32'h0);
        step(0, 0, 0, 1, 4'hF, 11'h100, 32'h0);
        step(0, 0, 0, 0, 4'hF, 11'h004, 32'h0);
        step(0, 0, 0, 0, 4'hF, 11'h004, 32'h0);
        rd_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
            if (obs_valid === 1'b1) begin
                n_valid++;
                if (first_cyc == 0) first_cyc = cyc;
            end
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL trcd_cycle: got valid=%b q=%h, want valid=%b q=%h",
                         obs_valid, obs_q, exp_valid, exp_q);
            end
        end
        n_cmp++;
        if (n_valid != 1 || first_cyc != rd_cyc + CAS_LAT) begin
            n_bad++;
            $display("FAIL trcd_guard: got %0d pulses first at +%0d, want 1 pulse at +%0d",
                     n_valid, first_cyc - rd_cyc, CAS_LAT);
        end
    endtask

    task automatic test_pipelined;
        logic [31:0] data [3];
        logic [31:0] got [$];
        int unsigned first_cyc, last_cyc;
        first_cyc = 0; last_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            data[i] = $urandom;
            step(0, 0, 0, 0, 4'h0, 11'(i + 1), data[i]);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'hF, 11'(i + 1), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
            if (obs_valid === 1'b1) begin
                got.push_back(obs_q);
                if (first_cyc == 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL pipe_cycle: got valid=%b q=%h, want valid=%b q=%h",
                         obs_valid, obs_q, exp_valid, exp_q);
            end
        end
        n_cmp++;
        if (got.size() != 3 || last_cyc - first_cyc != 2) begin
            n_bad++;
            $display("FAIL pipe_burst: got %0d pulses over %0d cycles, want 3 over 2",
                     got.size(), last_cyc - first_cyc);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got[i] !== data[i]) begin
                    n_bad++;
                    $display("FAIL pipe_order[%0d]: got %h, want %h", i, got[i], data[i]);
                end
            end
        end
    endtask

    task automatic test_precharge_reset;
        int n_valid;
        n_valid = 0;
        step(0, 0, 1, 1, 4'hF, 11'h0, 32'h0);
        step(0, 0, 0, 0, 4'hF, 11'h004, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 1, 1, 4'hF, 11'h0, 32'h0);
            if (obs_valid === 1'b1) n_valid++;
        end
        n_cmp++;
        if (n_valid != 0) begin
            n_bad++;
            $display("FAIL pre_read_ignored: got %0d pulses, want 0", n_valid);
        end
        step(0, 0, 0, 1, 4'hF, 11'h100, 32'h0);
        step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
        step(0, 0, 0, 0, 4'hF, 11'h004, 32'h0);
        step(0, 1, 0, 1, 4'hF, 11'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(i < 2, 1, 1, 1, 4'hF, 11'h0, 32'h0);
            if (obs_valid === 1'b1) n_valid++;
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL rst_cycle: got valid=%b q=%h, want valid=%b q=%h",
                         obs_valid, obs_q, exp_valid, exp_q);
            end
        end
        n_cmp++;
        if (n_valid != 0) begin
            n_bad++;
            $display("FAIL rst_cancel: got %0d pulses, want 0", n_valid);
        end
    endtask

    task automatic test_random;
        logic [10:0] rows [3];
        logic [10:0] a;
        logic        rst, csn, rasn, casn;
        logic [3:0]  wen;
        int unsigned kind;
        rows[0] = 11'h100; rows[1] = 11'h2A5; rows[2] = 11'h7FF;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) preload(waddr(rows[r], 11'(c)), $urandom);
        end
        for (int n = 0; n < 500; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            csn  = ($urandom_range(0, 7) == 0);
            kind = $urandom_range(0, 9);
            wen  = 4'hF;
            rasn = 1'b0; casn = 1'b0;
            a    = {1'($urandom), 7'h0, 3'($urandom_range(0, 7))};
            if (kind <= 1) begin
                rasn = 1'b0; casn = 1'b1; a = rows[$urandom_range(0, 2)];
            end else if (kind == 2 || kind == 9) begin
                rasn = 1'b1; casn = 1'($urandom);
            end else if (kind >= 6) begin
                wen = 4'($urandom);
            end
            step(rst, csn, rasn, casn, wen, a, $urandom);
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL rand_cycle %0d: got valid=%b q=%h, want valid=%b q=%h",
                         n, obs_valid, obs_q, exp_valid, exp_q);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 1, 4'hF, 11'h0, 32'h0);
            n_cmp++;
            if (obs_valid !== exp_valid || obs_q !== exp_q) begin
                n_bad++;
                $display("FAIL rand_drain: got valid=%b q=%h, want valid=%b q=%h",
                         obs_valid, obs_q, exp_valid, exp_q);
            end
        end
    endtask

    initial begin
        RST = 1'b1; bus.CSn = 1'b1; bus.RASn = 1'b1; bus.CASn = 1'b1;
        bus.WEn = 4'hF; bus.A = '0; bus.D = '0;
        m_open = 1'b0; m_row = '0; m_act_cyc = 0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_timing_guard();
        test_pipelined();
        test_precharge_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
